mem_arbiter: RTL and testbench

- Shares one single-ported synchronous RAM between the cpu32 instruction-fetch port and the data load/store port.
- Sits between the core's i_addr/i_data and d_addr/d_data_w/d_data_r/d_we buses and the RAM.
- Each requester uses a req/ack handshake. The arbiter issues at most one RAM access per cycle and tags each issued access through a fixed-latency pipeline, so every access returns to the requester that issued it.
- Round-robin on conflict; no requester starves.

---
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one synchronous RAM between fetch and data ports
module mem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  logic              ipend;
  logic              dpend;
  logic              last_grant;
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_p;
  logic              i_elig;
  logic              d_elig;
  logic              grant_i;
  logic              grant_d;
  logic [DW-1:0]     i_rdata_q;
  logic [DW-1:0]     d_rdata_q;

  // Arbitration and RAM command drive; nothing issues while reset is held.
  always_comb begin
    i_elig    = 1'b0;
    d_elig    = 1'b0;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_elig = rst_n & i_req & ~ipend;
    d_elig = rst_n & d_req & ~dpend;
    if (i_elig && d_elig) begin
      grant_d = (last_grant == PORT_I);
      grant_i = ~grant_d;
    end else begin
      grant_i = i_elig;
      grant_d = d_elig;
    end
    mem_en = grant_i | grant_d;
    if (grant_d) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (grant_i) begin
      mem_addr  = i_addr;
    end
  end

  // Tag pipeline: stage 0 captures the issue, the tail stage produces the ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      tag_p <= '0;
    end else begin
      tag_v[0] <= mem_en;
      tag_p[0] <= grant_d;
      for (int k = 1; k < RD_LAT; k++) begin
        tag_v[k] <= tag_v[k-1];
        tag_p[k] <= tag_p[k-1];
      end
    end
  end

  assign i_ack = tag_v[RD_LAT-1] & (tag_p[RD_LAT-1] == PORT_I);
  assign d_ack = tag_v[RD_LAT-1] & (tag_p[RD_LAT-1] == PORT_D);

  // Pending bits block re-issue of a held request until the cycle after its ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ipend      <= 1'b0;
      dpend      <= 1'b0;
      last_grant <= PORT_I;
    end else begin
      if (grant_i)    ipend <= 1'b1;
      else if (i_ack) ipend <= 1'b0;
      if (grant_d)    dpend <= 1'b1;
      else if (d_ack) dpend <= 1'b0;
      if (mem_en)     last_grant <= grant_d;
    end
  end

  // Read data holding registers; the ack cycle passes mem_rdata straight through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (i_ack) i_rdata_q <= mem_rdata;
      if (d_ack) d_rdata_q <= mem_rdata;
    end
  end

  assign i_rdata = i_ack ? mem_rdata : i_rdata_q;
  assign d_rdata = d_ack ? mem_rdata : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter at RD_LAT 1, 2 and 3
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;

  wire [2:0]       o_iack;
  wire [2:0]       o_dack;
  wire [2:0]       o_men;
  wire [2:0]       o_mwe;
  wire [2:0][31:0] o_ird;
  wire [2:0][31:0] o_drd;
  wire [2:0][31:0] o_maddr;
  wire [2:0][31:0] o_mwd;
  wire [2:0][31:0] o_mrd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance g has RD_LAT = g+1 and its own RAM model.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] ram [0:255];
    logic [31:0] pipe [0:g];

    mem_arbiter #(.AW(32), .DW(32), .RD_LAT(g + 1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_ack(o_iack[g]), .i_rdata(o_ird[g]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(o_dack[g]), .d_rdata(o_drd[g]),
      .mem_en(o_men[g]), .mem_we(o_mwe[g]), .mem_addr(o_maddr[g]),
      .mem_wdata(o_mwd[g]), .mem_rdata(o_mrd[g])
    );

    initial begin
      for (int k = 0; k < 256; k++) ram[k] = 32'hA000_0000 | k;
      ram[8'h40] = 32'hDEAD_BEEF;
      for (int k = 0; k <= g; k++) pipe[k] = '0;
    end

    always @(posedge clk) begin
      if (o_men[g]) begin
        pipe[0] <= ram[o_maddr[g][9:2]];
        if (o_mwe[g]) ram[o_maddr[g][9:2]] <= o_mwd[g];
      end
      for (int k = 1; k <= g; k++) pipe[k] <= pipe[k-1];
    end

    assign o_mrd[g] = pipe[g];
  end

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        en;
    logic        we;
    logic [31:0] ma;
    logic [31:0] mwd;
    logic        iack;
    logic        dack;
    logic [31:0] ird;
    logic [31:0] drd;
  } vec_t;

  vec_t vt [15];

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr, logic dw, logic [31:0] da,
                              logic [31:0] dwd, logic en, logic we, logic [31:0] ma,
                              logic [31:0] mwd, logic iack, logic dack, logic [31:0] ird,
                              logic [31:0] drd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.en = en; v.we = we; v.ma = ma; v.mwd = mwd; v.iack = iack; v.dack = dack;
    v.ird = ird; v.drd = drd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dwd);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Idle after reset on every instance.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        chk("idle_men", 32'(o_men[g]), 0);
        chk("idle_iack", 32'(o_iack[g]), 0);
        chk("idle_dack", 32'(o_dack[g]), 0);
        chk("idle_irdata", o_ird[g], 0);
        chk("idle_drdata", o_drd[g], 0);
      end
      next_cycle();
    end

    // Table-driven sequence on the RD_LAT=1 instance.
    vt[0]  = mk(0, 0,      0, 0, 0,      0,            0, 0, 0,      0,            0, 0, 32'h0,         32'h0);
    vt[1]  = mk(1, 'h100,  0, 0, 0,      0,            1, 0, 'h100,  0,            0, 0, 32'h0,         32'h0);
    vt[2]  = mk(1, 'h100,  0, 0, 0,      0,            0, 0, 0,      0,            1, 0, 32'hDEADBEEF,  32'h0);
    vt[3]  = mk(0, 0,      1, 1, 'h40,   'h12345678,   1, 1, 'h40,   'h12345678,   0, 0, 32'hDEADBEEF,  32'h0);
    vt[4]  = mk(0, 0,      1, 1, 'h40,   'h12345678,   0, 0, 0,      0,            0, 1, 32'hDEADBEEF,  32'hA0000010);
    vt[5]  = mk(0, 0,      1, 0, 'h40,   0,            1, 0, 'h40,   0,            0, 0, 32'hDEADBEEF,  32'hA0000010);
    vt[6]  = mk(0, 0,      1, 0, 'h40,   0,            0, 0, 0,      0,            0, 1, 32'hDEADBEEF,  32'h12345678);
    vt[7]  = mk(1, 'h104,  1, 0, 'h108,  0,            1, 0, 'h104,  0,            0, 0, 32'hDEADBEEF,  32'h12345678);
    vt[8]  = mk(1, 'h104,  1, 0, 'h108,  0,            1, 0, 'h108,  0,            1, 0, 32'hA0000041,  32'h12345678);
    vt[9]  = mk(1, 'h10C,  1, 0, 'h108,  0,            1, 0, 'h10C,  0,            0, 1, 32'hA0000041,  32'hA0000042);
    vt[10] = mk(1, 'h10C,  0, 0, 0,      0,            0, 0, 0,      0,            1, 0, 32'hA0000043,  32'hA0000042);
    vt[11] = mk(1, 'h100,  1, 1, 'h200,  'hCAFEF00D,   1, 1, 'h200,  'hCAFEF00D,   0, 0, 32'hA0000043,  32'hA0000042);
    vt[12] = mk(1, 'h100,  1, 1, 'h200,  'hCAFEF00D,   1, 0, 'h100,  0,            0, 1, 32'hA0000043,  32'hA0000080);
    vt[13] = mk(1, 'h100,  0, 0, 0,      0,            0, 0, 0,      0,            1, 0, 32'hDEADBEEF,  32'hA0000080);
    vt[14] = mk(0, 0,      0, 0, 0,      0,            0, 0, 0,      0,            0, 0, 32'hDEADBEEF,  32'hA0000080);
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].ir, vt[i].ia, vt[i].dr, vt[i].dw, vt[i].da, vt[i].dwd);
      @(negedge clk);
      chk($sformatf("v%0d_men", i),    32'(o_men[0]),  32'(vt[i].en));
      chk($sformatf("v%0d_mwe", i),    32'(o_mwe[0]),  32'(vt[i].we));
      chk($sformatf("v%0d_maddr", i),  o_maddr[0],     vt[i].ma);
      chk($sformatf("v%0d_mwdata", i), o_mwd[0],       vt[i].mwd);
      chk($sformatf("v%0d_iack", i),   32'(o_iack[0]), 32'(vt[i].iack));
      chk($sformatf("v%0d_dack", i),   32'(o_dack[0]), 32'(vt[i].dack));
      chk($sformatf("v%0d_irdata", i), o_ird[0],       vt[i].ird);
      chk($sformatf("v%0d_drdata", i), o_drd[0],       vt[i].drd);
      next_cycle();
    end

    // Continuous conflict at RD_LAT=1: D, I, D, I ... with no idle RAM cycles.
    do_reset();
    drive(1, 'h0, 1, 0, 'h4, 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_men", k),   32'(o_men[0]),  1);
      chk($sformatf("rr%0d_maddr", k), o_maddr[0],     (k % 2 == 0) ? 32'h4 : 32'h0);
      chk($sformatf("rr%0d_dack", k),  32'(o_dack[0]), (k % 2 == 1) ? 1 : 0);
      chk($sformatf("rr%0d_iack", k),  32'(o_iack[0]), (k >= 2 && k % 2 == 0) ? 1 : 0);
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0);

    // RD_LAT=3: fetch at cycle 5 acks at cycle 8, next fetch issues at cycle 9.
    do_reset();
    for (int c = 0; c < 14; c++) begin
      if (c >= 5 && c <= 8)       drive(1, 'h100, 0, 0, 0, 0);
      else if (c >= 9 && c <= 12) drive(1, 'h104, 0, 0, 0, 0);
      else                        drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("l3_c%0d_men", c),  32'(o_men[2]),
          (c == 5 || c == 9) ? 1 : 0);
      chk($sformatf("l3_c%0d_iack", c), 32'(o_iack[2]),
          (c == 8 || c == 12) ? 1 : 0);
      if (c == 5) chk("l3_maddr5", o_maddr[2], 32'h100);
      if (c == 9) chk("l3_maddr9", o_maddr[2], 32'h104);
      if (c == 8) chk("l3_irdata8", o_ird[2], 32'hDEADBEEF);
      if (c == 12) chk("l3_irdata12", o_ird[2], 32'hA0000041);
      next_cycle();
    end

    // RD_LAT=2: reset one cycle after a fetch issue discards the in-flight ack.
    do_reset();
    drive(1, 'h100, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_issue_men", 32'(o_men[1]), 1);
    next_cycle();
    rst_n = 1'b0;
    #1;
    chk("rst_men",    32'(o_men[1]),  0);
    chk("rst_mwe",    32'(o_mwe[1]),  0);
    chk("rst_maddr",  o_maddr[1],     0);
    chk("rst_mwdata", o_mwd[1],       0);
    chk("rst_iack",   32'(o_iack[1]), 0);
    chk("rst_dack",   32'(o_dack[1]), 0);
    chk("rst_irdata", o_ird[1],       0);
    chk("rst_drdata", o_drd[1],       0);
    @(negedge clk);
    chk("rst_iack_t1", 32'(o_iack[1]), 0);
    next_cycle();
    @(negedge clk);
    chk("rst_iack_t2", 32'(o_iack[1]), 0);
    chk("rst_men_t2",  32'(o_men[1]),  0);
    next_cycle();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_iack", c), 32'(o_iack[1]), 0);
      chk($sformatf("post_rst%0d_irdata", c), o_ird[1], 0);
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
